// File: rtl/fios_mont_seq.sv
`default_nettype none
// ============================================================================
//  Module   : fios_mont_seq
//  Brief    : Word-serial FIOS Montgomery multiplier, res = a*b*R^-1 mod p,
//             R = 2^(W*S), sequenced by an internal FSM (start/done handshake).
//  Revision : 1.0  initial release
// ============================================================================
module fios_mont_seq #(
    parameter int W         = 17,
    parameter int S         = 8,
    parameter int FINAL_SUB = 1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [S*W-1:0]   a_i,
    input  logic [S*W-1:0]   b_i,
    input  logic [S*W-1:0]   p_i,
    input  logic [W-1:0]     p_prime_0_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [S*W:0]     res_o
);

    localparam int CW = $clog2(S);
    localparam int SW = 2 * W + 2;

    localparam logic [CW-1:0] c_last    = CW'(S - 1);
    localparam logic [2:0]    c_st_idle = 3'd0;
    localparam logic [2:0]    c_st_m    = 3'd1;
    localparam logic [2:0]    c_st_acc  = 3'd2;
    localparam logic [2:0]    c_st_sub  = 3'd3;
    localparam logic [2:0]    c_st_done = 3'd4;

    logic [2:0]     r_state;
    logic [CW-1:0]  r_i;
    logic [CW-1:0]  r_j;
    logic [W-1:0]   r_a_w [0:S-1];
    logic [W-1:0]   r_b_w [0:S-1];
    logic [W-1:0]   r_p_w [0:S-1];
    logic [W-1:0]   r_pp;
    logic [W-1:0]   r_t_lo [0:S-1];
    logic [W-1:0]   r_t_hi;
    logic [W:0]     r_c;
    logic [W-1:0]   r_m;
    logic [W-1:0]   r_d [0:S-1];
    logic           r_borrow;
    logic [S*W:0]   r_res;

    logic [W-1:0]   w_x1;
    logic [W-1:0]   w_y1;
    logic [W-1:0]   w_x2;
    logic [W-1:0]   w_y2;
    logic [2*W-1:0] w_mul1;
    logic [2*W-1:0] w_mul2;
    logic [W-1:0]   w_mlow;
    logic [SW-1:0]  w_sum;
    logic [W+2:0]   w_top;
    logic [W:0]     w_diff;
    logic [W-1:0]   w_t_nxt [0:S-1];
    logic           w_load_res;
    logic [S*W:0]   w_res_next;

    // Two shared multipliers: in M they form m, in ACC they form a*b and m*p.
    always_comb begin
        w_x1   = r_a_w[r_i];
        w_y1   = r_b_w[r_j];
        w_mul1 = (2*W)'(w_x1) * (2*W)'(w_y1);
        w_mlow = r_t_lo[0] + w_mul1[W-1:0];
        w_x2   = (r_state == c_st_m) ? w_mlow : r_m;
        w_y2   = (r_state == c_st_m) ? r_pp   : r_p_w[r_j];
        w_mul2 = (2*W)'(w_x2) * (2*W)'(w_y2);
        w_sum  = SW'(r_t_lo[r_j]) + SW'(w_mul1) + SW'(w_mul2) + SW'(r_c);
        w_top  = (W+3)'(r_t_hi) + (W+3)'(w_sum[SW-1:W]);
        w_diff = {1'b0, r_t_lo[r_j]} - {1'b0, r_p_w[r_j]} - (W+1)'(r_borrow);
    end

    // Accumulator write-back for the current ACC step (shifted down one word).
    always_comb begin
        for (int k = 0; k < S; k++) begin
            w_t_nxt[k] = r_t_lo[k];
            if (r_state == c_st_acc) begin
                if ((r_j != '0) && ((r_j - 1'b1) == CW'(k)))
                    w_t_nxt[k] = w_sum[W-1:0];
                if ((r_j == c_last) && (k == S - 1))
                    w_t_nxt[k] = w_top[W-1:0];
            end
        end
    end

    generate
        if (FINAL_SUB != 0) begin : g_final_sub
            logic w_use_d;
            always_comb begin
                w_load_res = (r_state == c_st_sub) && (r_j == c_last);
                w_use_d    = (r_t_hi != '0) || !w_diff[W];
                w_res_next = '0;
                for (int k = 0; k < S; k++) begin
                    if (w_use_d)
                        w_res_next[k*W +: W] = (k == S - 1) ? w_diff[W-1:0] : r_d[k];
                    else
                        w_res_next[k*W +: W] = r_t_lo[k];
                end
            end
        end else begin : g_no_sub
            always_comb begin
                w_load_res = (r_state == c_st_acc) && (r_i == c_last) && (r_j == c_last);
                w_res_next = '0;
                w_res_next[S*W] = w_top[W];
                for (int k = 0; k < S; k++)
                    w_res_next[k*W +: W] = w_t_nxt[k];
            end
        end
    endgenerate

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state  <= c_st_idle;
            r_i      <= '0;
            r_j      <= '0;
            r_pp     <= '0;
            r_t_hi   <= '0;
            r_c      <= '0;
            r_m      <= '0;
            r_borrow <= 1'b0;
            r_res    <= '0;
            for (int k = 0; k < S; k++) begin
                r_a_w[k]  <= '0;
                r_b_w[k]  <= '0;
                r_p_w[k]  <= '0;
                r_t_lo[k] <= '0;
                r_d[k]    <= '0;
            end
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start_i) begin
                        for (int k = 0; k < S; k++) begin
                            r_a_w[k]  <= a_i[k*W +: W];
                            r_b_w[k]  <= b_i[k*W +: W];
                            r_p_w[k]  <= p_i[k*W +: W];
                            r_t_lo[k] <= '0;
                        end
                        r_pp    <= p_prime_0_i;
                        r_t_hi  <= '0;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_state <= c_st_m;
                    end
                end
                c_st_m: begin
                    r_m     <= w_mul2[W-1:0];
                    r_c     <= '0;
                    r_j     <= '0;
                    r_state <= c_st_acc;
                end
                c_st_acc: begin
                    r_c <= w_sum[2*W:W];
                    for (int k = 0; k < S; k++)
                        r_t_lo[k] <= w_t_nxt[k];
                    if (r_j == c_last) begin
                        r_t_hi <= W'(w_top[W+2:W]);
                        r_j    <= '0;
                        if (r_i != c_last) begin
                            r_i     <= r_i + 1'b1;
                            r_state <= c_st_m;
                        end else begin
                            r_borrow <= 1'b0;
                            r_state  <= (FINAL_SUB != 0) ? c_st_sub : c_st_done;
                        end
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end
                c_st_sub: begin
                    r_d[r_j] <= w_diff[W-1:0];
                    r_borrow <= w_diff[W];
                    if (r_j == c_last) begin
                        r_j     <= '0;
                        r_state <= c_st_done;
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
            if (w_load_res)
                r_res <= w_res_next;
        end
    end

    assign busy_o = (r_state != c_st_idle);
    assign done_o = (r_state == c_st_done);
    assign res_o  = r_res;

endmodule
`default_nettype wire
